// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback arbiter.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DEF_DATA_W = 32;
    localparam int NUM_WB_REQ = 2;

    // Requester indices within a grant vector.
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    // One writeback request at the default data width.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] data;
    } wb_req_t;

    // The value records which requester was served most recently.
    // After reset the value is LG_MEM, so the ALU is offered priority first.
    typedef enum logic {
        LG_MEM = 1'b0,
        LG_ALU = 1'b1
    } last_grant_e;

endpackage

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-requester writeback queue; exposes every entry's address for hazard checks.
module wb_fifo
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               push_i,
    input  logic [REG_ADDR_W-1:0]              push_addr_i,
    input  logic [DATA_W-1:0]                  push_data_i,
    input  logic                               pop_i,
    output logic                               full_o,
    output logic                               empty_o,
    output logic [$clog2(DEPTH+1)-1:0]         count_o,
    output logic [REG_ADDR_W-1:0]              head_addr_o,
    output logic [DATA_W-1:0]                  head_data_o,
    output logic [DEPTH-1:0]                   ent_vld_o,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]   ent_addr_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]                 rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]                 count_q;
    logic [DEPTH-1:0]                 vld_q;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] addr_q;
    logic [DEPTH-1:0][DATA_W-1:0]     data_q;
    logic                             do_push, do_pop;

    assign full_o      = (count_q == CNT_W'(DEPTH));
    assign empty_o     = (count_q == '0);
    assign count_o     = count_q;
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];
    assign ent_vld_o   = vld_q;
    assign ent_addr_o  = addr_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Queue bookkeeping: pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            vld_q    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
                vld_q[wr_ptr_q] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
                vld_q[rd_ptr_q] <= 1'b0;
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry payload storage; validity is tracked separately, so no reset needed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            addr_q[wr_ptr_q] <= push_addr_i;
            data_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Two-source writeback arbiter feeding a single register-file write port.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                            CLK,
    input  logic                            reset_n,
    input  logic                            alu_valid,
    input  logic [REG_ADDR_W-1:0]           alu_addr,
    input  logic [DATA_W-1:0]               alu_data,
    output logic                            alu_ready,
    input  logic                            mem_valid,
    input  logic [REG_ADDR_W-1:0]           mem_addr,
    input  logic [DATA_W-1:0]               mem_data,
    output logic                            mem_ready,
    output logic                            wr_en,
    output logic [REG_ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]               wr_data,
    input  logic [REG_ADDR_W-1:0]           chk_addr1,
    input  logic [REG_ADDR_W-1:0]           chk_addr2,
    output logic                            hazard1,
    output logic                            hazard2,
    output logic [$clog2(2*DEPTH+2)-1:0]    pending
);

    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int PEND_W = $clog2(2*DEPTH+2);

    logic                             alu_push, mem_push;
    logic                             alu_full, mem_full, alu_empty, mem_empty;
    logic [CNT_W-1:0]                 alu_cnt, mem_cnt;
    logic [REG_ADDR_W-1:0]            alu_head_addr, mem_head_addr;
    logic [DATA_W-1:0]                alu_head_data, mem_head_data;
    logic [DEPTH-1:0]                 alu_vld, mem_vld;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] alu_ent_addr, mem_ent_addr;
    logic [NUM_WB_REQ-1:0]            grant;

    last_grant_e                      last_grant_q, last_grant_d;
    logic                             wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0]            wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]                wr_data_q, wr_data_d;

    // Ready reflects only queue occupancy (and reset), never the valid inputs.
    assign alu_ready = reset_n && !alu_full;
    assign mem_ready = reset_n && !mem_full;

    // Writes to x0 complete the handshake but are dropped here.
    assign alu_push = alu_valid && alu_ready && (alu_addr != '0);
    assign mem_push = mem_valid && mem_ready && (mem_addr != '0);

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_alu_fifo (
        .clk_i(CLK), .rst_ni(reset_n),
        .push_i(alu_push), .push_addr_i(alu_addr), .push_data_i(alu_data),
        .pop_i(grant[REQ_ALU]),
        .full_o(alu_full), .empty_o(alu_empty), .count_o(alu_cnt),
        .head_addr_o(alu_head_addr), .head_data_o(alu_head_data),
        .ent_vld_o(alu_vld), .ent_addr_o(alu_ent_addr)
    );

    wb_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_mem_fifo (
        .clk_i(CLK), .rst_ni(reset_n),
        .push_i(mem_push), .push_addr_i(mem_addr), .push_data_i(mem_data),
        .pop_i(grant[REQ_MEM]),
        .full_o(mem_full), .empty_o(mem_empty), .count_o(mem_cnt),
        .head_addr_o(mem_head_addr), .head_data_o(mem_head_data),
        .ent_vld_o(mem_vld), .ent_addr_o(mem_ent_addr)
    );

    // Round-robin pick of one head entry per cycle and next write-port values.
    always_comb begin
        grant        = '0;
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        if (!alu_empty && (mem_empty || last_grant_q == LG_MEM)) begin
            grant[REQ_ALU] = 1'b1;
            last_grant_d   = LG_ALU;
            wr_en_d        = 1'b1;
            wr_addr_d      = alu_head_addr;
            wr_data_d      = alu_head_data;
        end else if (!mem_empty) begin
            grant[REQ_MEM] = 1'b1;
            last_grant_d   = LG_MEM;
            wr_en_d        = 1'b1;
            wr_addr_d      = mem_head_addr;
            wr_data_d      = mem_head_data;
        end
    end

    // Write-port stage and arbitration history.
    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= LG_MEM;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;

    // In-flight work: both queues plus the occupied write stage.
    assign pending = PEND_W'(alu_cnt) + PEND_W'(mem_cnt) + PEND_W'(wr_en_q);

    function automatic logic addr_hit(
        input logic [REG_ADDR_W-1:0]            chk,
        input logic                             wr_v,
        input logic [REG_ADDR_W-1:0]            wr_a,
        input logic [DEPTH-1:0]                 a_vld,
        input logic [DEPTH-1:0][REG_ADDR_W-1:0] a_addr,
        input logic [DEPTH-1:0]                 m_vld,
        input logic [DEPTH-1:0][REG_ADDR_W-1:0] m_addr
    );
        logic hit;
        hit = wr_v && (wr_a == chk);
        for (int i = 0; i < DEPTH; i++) begin
            if (a_vld[i] && (a_addr[i] == chk)) hit = 1'b1;
            if (m_vld[i] && (m_addr[i] == chk)) hit = 1'b1;
        end
        return (chk != '0) && hit;
    endfunction

    assign hazard1 = addr_hit(chk_addr1, wr_en_q, wr_addr_q, alu_vld, alu_ent_addr, mem_vld, mem_ent_addr);
    assign hazard2 = addr_hit(chk_addr2, wr_en_q, wr_addr_q, alu_vld, alu_ent_addr, mem_vld, mem_ent_addr);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for the writeback arbiter.
module tb_regfile_wb_arbiter;

    logic        CLK = 1'b0;
    logic        reset_n;
    logic        alu_valid, mem_valid;
    logic [4:0]  alu_addr, mem_addr;
    logic [31:0] alu_data, mem_data;
    logic        alu_ready, mem_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  chk_addr1, chk_addr2;
    logic        hazard1, hazard2;
    logic [2:0]  pending;

    int n_pass  = 0;
    int n_total = 0;

    always #5 CLK = ~CLK;

    regfile_wb_arbiter #(.DEPTH(2), .DATA_W(32)) dut (
        .CLK(CLK), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
        .hazard1(hazard1), .hazard2(hazard2), .pending(pending)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle_inputs();
        chk_addr1 = 5'd5; chk_addr2 = 5'd0;
        #1;
        n_total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %0b want 0", wr_en); else n_pass++;
        n_total++; if (pending !== 3'd0) $display("FAIL reset_pending: got %0d want 0", pending); else n_pass++;
        n_total++; if (alu_ready !== 1'b0) $display("FAIL reset_alu_ready: got %0b want 0", alu_ready); else n_pass++;
        n_total++; if (mem_ready !== 1'b0) $display("FAIL reset_mem_ready: got %0b want 0", mem_ready); else n_pass++;
        n_total++; if (hazard1 !== 1'b0) $display("FAIL reset_hazard1: got %0b want 0", hazard1); else n_pass++;
        n_total++; if (wr_addr !== 5'd0 || wr_data !== 32'd0)
            $display("FAIL reset_wr_port: got %0d/%h want 0/0", wr_addr, wr_data); else n_pass++;
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        n_total++; if (alu_ready !== 1'b1 || mem_ready !== 1'b1)
            $display("FAIL release_ready: got %0b%0b want 11", alu_ready, mem_ready); else n_pass++;
        tick();
    endtask

    task automatic test_single();
        chk_addr1 = 5'd5;
        alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL single_ready: got %0b want 1", alu_ready); else n_pass++;
        tick();
        alu_valid = 1'b0;
        n_total++; if (wr_en !== 1'b0) $display("FAIL single_early_wr: got %0b want 0", wr_en); else n_pass++;
        n_total++; if (pending !== 3'd1) $display("FAIL single_pending_q: got %0d want 1", pending); else n_pass++;
        n_total++; if (hazard1 !== 1'b1) $display("FAIL single_hazard_q: got %0b want 1", hazard1); else n_pass++;
        tick();
        n_total++; if (wr_en !== 1'b1) $display("FAIL single_wr_en: got %0b want 1", wr_en); else n_pass++;
        n_total++; if (wr_addr !== 5'd5) $display("FAIL single_wr_addr: got %0d want 5", wr_addr); else n_pass++;
        n_total++; if (wr_data !== 32'hDEADBEEF) $display("FAIL single_wr_data: got %h want deadbeef", wr_data); else n_pass++;
        n_total++; if (hazard1 !== 1'b1) $display("FAIL single_hazard_wr: got %0b want 1", hazard1); else n_pass++;
        n_total++; if (pending !== 3'd1) $display("FAIL single_pending_wr: got %0d want 1", pending); else n_pass++;
        tick();
        n_total++; if (wr_en !== 1'b0) $display("FAIL single_pulse_end: got %0b want 0", wr_en); else n_pass++;
        n_total++; if (wr_addr !== 5'd5 || wr_data !== 32'hDEADBEEF)
            $display("FAIL single_hold: got %0d/%h want 5/deadbeef", wr_addr, wr_data); else n_pass++;
        n_total++; if (pending !== 3'd0) $display("FAIL single_pending_done: got %0d want 0", pending); else n_pass++;
        n_total++; if (hazard1 !== 1'b0) $display("FAIL single_hazard_done: got %0b want 0", hazard1); else n_pass++;
    endtask

    task automatic test_addr0();
        chk_addr1 = 5'd0; chk_addr2 = 5'd0;
        alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234;
        n_total++; if (alu_ready !== 1'b1) $display("FAIL addr0_ready: got %0b want 1", alu_ready); else n_pass++;
        tick();
        alu_valid = 1'b0;
        n_total++; if (pending !== 3'd0) $display("FAIL addr0_pending: got %0d want 0", pending); else n_pass++;
        n_total++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0)
            $display("FAIL addr0_hazard: got %0b%0b want 00", hazard1, hazard2); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++; if (wr_en !== 1'b0) $display("FAIL addr0_no_write: got %0b want 0 (cycle %0d)", wr_en, i); else n_pass++;
        end
    endtask

    task automatic test_contend();
        logic [4:0]  exp_addr [8];
        logic [31:0] exp_data;
        int ai, mi, writes, max_pend;
        bit a_acc, m_acc, saw_alu_nr, saw_mem_nr;
        exp_addr = '{5'd1, 5'd5, 5'd2, 5'd6, 5'd3, 5'd7, 5'd4, 5'd8};
        ai = 0; mi = 0; writes = 0; max_pend = 0;
        saw_alu_nr = 1'b0; saw_mem_nr = 1'b0;
        do_reset();
        tick();
        for (int cyc = 0; cyc < 30; cyc++) begin
            alu_valid = (ai < 4); alu_addr = 5'(ai + 1); alu_data = 32'hA000_0000 + 32'(ai + 1);
            mem_valid = (mi < 4); mem_addr = 5'(mi + 5); mem_data = 32'hB000_0000 + 32'(mi + 5);
            a_acc = alu_valid && alu_ready;
            m_acc = mem_valid && mem_ready;
            if (!alu_ready) saw_alu_nr = 1'b1;
            if (!mem_ready) saw_mem_nr = 1'b1;
            tick();
            if (a_acc) ai++;
            if (m_acc) mi++;
            if (int'(pending) > max_pend) max_pend = int'(pending);
            if (wr_en === 1'b1) begin
                n_total++;
                if (writes >= 8) begin
                    $display("FAIL contend_extra_write: got addr %0d want no write", wr_addr);
                end else begin
                    exp_data = (exp_addr[writes] <= 5'd4) ? 32'hA000_0000 + 32'(exp_addr[writes])
                                                          : 32'hB000_0000 + 32'(exp_addr[writes]);
                    if (wr_addr !== exp_addr[writes] || wr_data !== exp_data)
                        $display("FAIL contend_write%0d: got %0d/%h want %0d/%h",
                                 writes, wr_addr, wr_data, exp_addr[writes], exp_data);
                    else n_pass++;
                end
                writes++;
            end
        end
        idle_inputs();
        n_total++; if (writes != 8) $display("FAIL contend_count: got %0d want 8", writes); else n_pass++;
        n_total++; if (!saw_alu_nr) $display("FAIL contend_alu_backpressure: got 0 want 1"); else n_pass++;
        n_total++; if (!saw_mem_nr) $display("FAIL contend_mem_backpressure: got 0 want 1"); else n_pass++;
        n_total++; if (max_pend > 5) $display("FAIL contend_pending_max: got %0d want <=5", max_pend); else n_pass++;
        n_total++; if (pending !== 3'd0) $display("FAIL contend_drained: got %0d want 0", pending); else n_pass++;
    endtask

    task automatic test_mem_full();
        do_reset();
        tick();
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h14;
        mem_valid = 1'b1; mem_addr = 5'd21; mem_data = 32'h15;
        tick();
        alu_valid = 1'b0;
        mem_addr = 5'd22; mem_data = 32'h16;
        n_total++; if (mem_ready !== 1'b1) $display("FAIL full_ready_e1: got %0b want 1", mem_ready); else n_pass++;
        n_total++; if (pending !== 3'd2) $display("FAIL full_pending_e1: got %0d want 2", pending); else n_pass++;
        tick();
        mem_addr = 5'd23; mem_data = 32'h17;
        n_total++; if (mem_ready !== 1'b0) $display("FAIL full_ready_e2: got %0b want 0", mem_ready); else n_pass++;
        n_total++; if (pending !== 3'd3) $display("FAIL full_pending_peak: got %0d want 3", pending); else n_pass++;
        n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'd20)
            $display("FAIL full_wr_e2: got %0b/%0d want 1/20", wr_en, wr_addr); else n_pass++;
        tick();
        n_total++; if (mem_ready !== 1'b1) $display("FAIL full_ready_e3: got %0b want 1", mem_ready); else n_pass++;
        n_total++; if (pending !== 3'd2) $display("FAIL full_pending_e3: got %0d want 2", pending); else n_pass++;
        n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'd21)
            $display("FAIL full_wr_e3: got %0b/%0d want 1/21", wr_en, wr_addr); else n_pass++;
        tick();
        mem_valid = 1'b0;
        n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'd22 || pending !== 3'd2)
            $display("FAIL full_wr_e4: got %0b/%0d/%0d want 1/22/2", wr_en, wr_addr, pending); else n_pass++;
        tick();
        n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'd23 || wr_data !== 32'h17 || pending !== 3'd1)
            $display("FAIL full_wr_e5: got %0b/%0d/%h/%0d want 1/23/17/1", wr_en, wr_addr, wr_data, pending); else n_pass++;
        tick();
        n_total++; if (wr_en !== 1'b0 || pending !== 3'd0)
            $display("FAIL full_done: got %0b/%0d want 0/0", wr_en, pending); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick();
        chk_addr1 = 5'd11; chk_addr2 = 5'd12;
        alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'hAA;
        mem_valid = 1'b1; mem_addr = 5'd11; mem_data = 32'hBB;
        tick();
        mem_valid = 1'b0;
        alu_addr = 5'd12; alu_data = 32'hCC;
        tick();
        idle_inputs();
        n_total++; if (pending !== 3'd3) $display("FAIL mid_pending_before: got %0d want 3", pending); else n_pass++;
        n_total++; if (hazard1 !== 1'b1 || hazard2 !== 1'b1)
            $display("FAIL mid_hazard_before: got %0b%0b want 11", hazard1, hazard2); else n_pass++;
        n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'd10)
            $display("FAIL mid_wr_before: got %0b/%0d want 1/10", wr_en, wr_addr); else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++; if (wr_en !== 1'b0) $display("FAIL mid_wr_en: got %0b want 0", wr_en); else n_pass++;
        n_total++; if (pending !== 3'd0) $display("FAIL mid_pending: got %0d want 0", pending); else n_pass++;
        n_total++; if (hazard1 !== 1'b0 || hazard2 !== 1'b0)
            $display("FAIL mid_hazard: got %0b%0b want 00", hazard1, hazard2); else n_pass++;
        n_total++; if (alu_ready !== 1'b0 || mem_ready !== 1'b0)
            $display("FAIL mid_ready: got %0b%0b want 00", alu_ready, mem_ready); else n_pass++;
        @(negedge CLK);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++; if (wr_en !== 1'b0 || pending !== 3'd0)
                $display("FAIL mid_after_release: got %0b/%0d want 0/0 (cycle %0d)", wr_en, pending, i); else n_pass++;
        end
    endtask

    task automatic test_mem_stream();
        do_reset();
        tick();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h33;
        tick();
        alu_valid = 1'b0;
        tick();
        n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'd3)
            $display("FAIL stream_alu_first: got %0b/%0d want 1/3", wr_en, wr_addr); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            mem_valid = 1'b1; mem_addr = 5'(24 + k); mem_data = 32'(24 + k);
            n_total++; if (mem_ready !== 1'b1) $display("FAIL stream_ready%0d: got %0b want 1", k, mem_ready); else n_pass++;
            tick();
            if (k >= 1) begin
                n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'(23 + k))
                    $display("FAIL stream_wr%0d: got %0b/%0d want 1/%0d", k, wr_en, wr_addr, 23 + k); else n_pass++;
            end
        end
        mem_valid = 1'b0;
        tick();
        n_total++; if (wr_en !== 1'b1 || wr_addr !== 5'd27 || wr_data !== 32'd27)
            $display("FAIL stream_last: got %0b/%0d/%0d want 1/27/27", wr_en, wr_addr, wr_data); else n_pass++;
        tick();
        n_total++; if (wr_en !== 1'b0) $display("FAIL stream_idle: got %0b want 0", wr_en); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_addr0();
        test_contend();
        test_mem_full();
        test_reset_mid();
        test_mem_stream();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter DEPTH, default 2, SHALL set entries per requester queue (power of two, >=2).
REQ-002 Parameter DATA_W, default 32, SHALL set write-data width.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 alu_valid, alu_addr[4:0], alu_data[DATA_W-1:0]  input  SHALL form ALU writeback request; alu_ready  output  1  SHALL be accept.
REQ-006 mem_valid, mem_addr[4:0], mem_data[DATA_W-1:0]  input  SHALL form load writeback request; mem_ready  output  1  SHALL be accept.
REQ-007 wr_en  output  1, wr_addr  output  5, wr_data  output  DATA_W  SHALL drive the register file's single write port.
REQ-008 chk_addr1, chk_addr2  input  5  SHALL be the register file read addresses being checked.
REQ-009 hazard1, hazard2  output  1  SHALL flag a pending write to chk_addr1/chk_addr2.
REQ-010 pending  output  $clog2(2*DEPTH+2)  SHALL count writes accepted but not yet issued, including the wr_* stage.

Function
REQ-011 Handshake: transfer occurs on a rising edge where valid && ready; ready SHALL equal "queue not full", with no combinational path from valid to ready.
REQ-012 A transfer with addr == 0 SHALL complete the handshake and be discarded (not queued, never written).
REQ-013 Each requester SHALL own a DEPTH-entry FIFO; entries from one requester SHALL issue in acceptance order.
REQ-014 A full FIFO SHALL hold ready low even if it pops that cycle (no same-cycle refill).
REQ-015 Each cycle, if any FIFO is non-empty, exactly one entry SHALL be popped and registered into wr_en/wr_addr/wr_data; otherwise wr_en SHALL be 0 next cycle.
REQ-016 Arbitration SHALL be round-robin: a last_grant bit SHALL give the other requester priority when both are non-empty; a single non-empty FIFO SHALL always win.
REQ-017 Latency: a request accepted at edge N into an empty, uncontended queue SHALL appear with wr_en=1 during the cycle after edge N+1 (register file captures at edge N+2).
REQ-018 wr_en SHALL be high for exactly one cycle per issued entry; wr_addr/wr_data SHALL hold their last value when wr_en=0.
REQ-019 hazardN SHALL be 1 when chk_addrN != 0 and matches any valid FIFO entry or the wr_* stage with wr_en=1; combinational from chk_addrN and state.
REQ-020 No ordering SHALL be guaranteed between requesters targeting the same address; hazards SHALL remain asserted until the last pending match issues.
REQ-021 Simultaneous push and pop on the same non-full FIFO SHALL keep its count unchanged.
REQ-022 pending SHALL update the same edge as pushes/pops, never exceed 2*DEPTH+1, and never underflow.

Reset
REQ-023 reset_n low SHALL immediately clear both FIFOs, wr_en=0, wr_addr=0, wr_data=0, last_grant=0 (ALU has priority first), pending=0.
REQ-024 During reset, alu_ready and mem_ready SHALL be 0; both SHALL be 1 the first cycle after reset_n deasserts.
REQ-025 Reset mid-operation SHALL drop all queued and in-flight writes; no wr_en pulse SHALL follow deassertion until a new transfer.

Structure
REQ-026 Shared package regfile_pkg SHALL hold REG_ADDR_W=5, DATA_W default, NUM_WB_REQ=2, and the wb_req_t struct (addr, data).
REQ-027 One sub-module wb_fifo (parameterised depth/width, push/pop/full/empty/count, per-entry addr visible for hazard compare) SHALL be instantiated twice.
REQ-028 Round-robin select, wr_* output register and hazard compare SHALL live in the top module.

Verification
REQ-029 Single ALU write addr=5 data=0xDEADBEEF after reset -> wr_en pulse exactly 2 edges after accept, wr_addr=5, wr_data=0xDEADBEEF; hazard1 high with chk_addr1=5 until the pulse ends.
REQ-030 ALU and MEM both valid every cycle, addrs 1..8 -> wr_en alternates ALU/MEM/ALU/MEM; per-source order preserved; ready drops when a FIFO holds 2.
REQ-031 Write to addr 0 with data 0x1234 -> handshake completes, no wr_en pulse, pending stays 0, hazard with chk_addr=0 stays 0.
REQ-032 Fill MEM FIFO (2 entries), hold mem_valid -> mem_ready=0 until first pop edge, then 1 next cycle; pending peaks at 3 (2 queued + wr stage).
REQ-033 Assert reset_n low asynchronously mid-cycle with 3 writes pending -> wr_en, pending, hazards drop immediately; no writes issue after release.
REQ-034 Only MEM traffic for 4 writes after ALU last granted -> MEM granted every cycle with no idle bubbles.
